// File: rtl/sram_req_arbiter.sv
// Two-requester arbiter onto one SRAM-like port, with an in-order response router.
// Define SRAM_ARB_RR_EN for round-robin conflict resolution; default is fixed priority (requester 1 wins).
module sram_req_arbiter #(
    parameter int OT_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      m0_req,
    input  logic                      m0_wr,
    input  logic [1:0]                m0_size,
    input  logic [3:0]                m0_wstrb,
    input  logic [31:0]               m0_addr,
    input  logic [31:0]               m0_wdata,
    output logic                      m0_addr_ok,
    output logic                      m0_data_ok,
    output logic [31:0]               m0_rdata,

    input  logic                      m1_req,
    input  logic                      m1_wr,
    input  logic [1:0]                m1_size,
    input  logic [3:0]                m1_wstrb,
    input  logic [31:0]               m1_addr,
    input  logic [31:0]               m1_wdata,
    output logic                      m1_addr_ok,
    output logic                      m1_data_ok,
    output logic [31:0]               m1_rdata,

    output logic                      s_req,
    output logic                      s_wr,
    output logic [1:0]                s_size,
    output logic [3:0]                s_wstrb,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    input  logic                      s_addr_ok,
    input  logic                      s_data_ok,
    input  logic [31:0]               s_rdata,

    output logic [$clog2(OT_DEPTH):0] ot_cnt,
    output logic                      ot_err
);

    localparam int PW = $clog2(OT_DEPTH);

    typedef enum logic [1:0] {
        ARB_OPEN  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;

    logic [OT_DEPTH-1:0] r_fifo;
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [PW:0]         r_cnt;
    logic                r_err;
`ifdef SRAM_ARB_RR_EN
    logic                r_last;
`endif

    logic w_grant;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_full  = (r_cnt == (PW+1)'(OT_DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_head  = r_fifo[r_rptr];

    // Grant selection: a pending lock overrides arbitration
    always_comb begin
        w_grant = 1'b0;
        case (r_state)
            ARB_LOCK0: w_grant = 1'b0;
            ARB_LOCK1: w_grant = 1'b1;
            default: begin
                if (m0_req && m1_req) begin
`ifdef SRAM_ARB_RR_EN
                    w_grant = ~r_last;
`else
                    w_grant = 1'b1;
`endif
                end else begin
                    w_grant = m1_req;
                end
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        // Locked requester withdrawing its request releases the lock regardless of downstream
        if ((r_state == ARB_LOCK0 && !m0_req) || (r_state == ARB_LOCK1 && !m1_req))
            w_state_nxt = ARB_OPEN;
        else if (s_req && !s_addr_ok)
            w_state_nxt = w_grant ? ARB_LOCK1 : ARB_LOCK0;
        else
            w_state_nxt = ARB_OPEN;
    end

    assign s_req = ~reset & (m0_req | m1_req) & ~w_full;

    always_comb begin
        s_wr    = 1'b0;
        s_size  = '0;
        s_wstrb = '0;
        s_addr  = '0;
        s_wdata = '0;
        if (!reset) begin
            if (w_grant) begin
                s_wr    = m1_wr;
                s_size  = m1_size;
                s_wstrb = m1_wstrb;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
            end else begin
                s_wr    = m0_wr;
                s_size  = m0_size;
                s_wstrb = m0_wstrb;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
            end
        end
    end

    assign w_push = s_req & s_addr_ok;
    assign w_pop  = ~reset & s_data_ok & ~w_empty;

    assign m0_addr_ok = w_push & ~w_grant;
    assign m1_addr_ok = w_push &  w_grant;
    assign m0_data_ok = w_pop & ~w_head;
    assign m1_data_ok = w_pop &  w_head;
    assign m0_rdata   = m0_data_ok ? s_rdata : '0;
    assign m1_rdata   = m1_data_ok ? s_rdata : '0;

    assign ot_cnt = r_cnt;
    assign ot_err = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_OPEN;
            r_fifo  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            r_last  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_fifo[r_wptr] <= w_grant;
                r_wptr         <= r_wptr + PW'(1);
`ifdef SRAM_ARB_RR_EN
                r_last         <= w_grant;
`endif
            end
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (s_data_ok && w_empty)
                r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: expected responses queued at issue, checked by a monitor on data_ok.
module tb_sram_req_arbiter;

    localparam int OT = 4;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size, s_size;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr, s_addr_ok, s_data_ok;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [2:0]  ot_cnt;
    logic        ot_err;

    always #5 clk = ~clk;

    sram_req_arbiter #(.OT_DEPTH(OT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
        .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
        .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .ot_cnt(ot_cnt), .ot_err(ot_err)
    );

    typedef struct {
        logic        id;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: every data_ok pops one expected {id, rdata}
    always @(negedge clk) begin
        if (!reset && (m0_data_ok || m1_data_ok)) begin
            if (q.size() == 0) begin
                chk("resp_unexpected", {30'd0, m1_data_ok, m0_data_ok}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_id", {30'd0, m1_data_ok, m0_data_ok}, e.id ? 32'd2 : 32'd1);
                chk("resp_rdata", e.id ? m1_rdata : m0_rdata, e.rdata);
                chk("resp_other_rdata", e.id ? m0_rdata : m1_rdata, 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_m();
        m0_req = 0; m0_wr = 0; m0_size = 0; m0_wstrb = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_size = 0; m1_wstrb = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic accept(input logic id, input logic [31:0] addr);
        clr_m();
        if (id) begin m1_req = 1; m1_addr = addr; m1_size = 2; end
        else    begin m0_req = 1; m0_addr = addr; m0_size = 2; end
        s_addr_ok = 1;
        #3;
        chk("acc_addr", s_addr, addr);
        chk("acc_ok", {30'd0, m1_addr_ok, m0_addr_ok}, id ? 32'd2 : 32'd1);
        cyc();
        clr_m();
        s_addr_ok = 0;
    endtask

    task automatic respond(input logic id, input logic [31:0] d);
        exp_t e;
        e.id = id;
        e.rdata = d;
        q.push_back(e);
        s_data_ok = 1;
        s_rdata = d;
        cyc();
        s_data_ok = 0;
        s_rdata = 0;
    endtask

    initial begin
        logic [3:0] pat;
        logic       win;
        clr_m();
        reset = 1; s_addr_ok = 1; s_data_ok = 0; s_rdata = 0;
        m0_req = 1; m0_addr = 32'h1234;
        cyc(); cyc();
        #3;
        chk("rst_s_req", {31'd0, s_req}, 32'd0);
        chk("rst_addr_ok", {31'd0, m0_addr_ok}, 32'd0);
        chk("rst_ot_cnt", {29'd0, ot_cnt}, 32'd0);
        chk("rst_ot_err", {31'd0, ot_err}, 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        cyc();
        reset = 0; s_addr_ok = 0; clr_m();
        cyc();

        // single m0 read
        m0_req = 1; m0_addr = 32'h1C00_0000; m0_size = 2; s_addr_ok = 1;
        #3;
        chk("t1_s_req", {31'd0, s_req}, 32'd1);
        chk("t1_s_addr", s_addr, 32'h1C00_0000);
        chk("t1_s_size", {30'd0, s_size}, 32'd2);
        chk("t1_addr_ok", {30'd0, m1_addr_ok, m0_addr_ok}, 32'd1);
        chk("t1_cnt0", {29'd0, ot_cnt}, 32'd0);
        cyc();
        clr_m(); s_addr_ok = 0;
        #3 chk("t1_cnt1", {29'd0, ot_cnt}, 32'd1);
        cyc();
        respond(1'b0, 32'hDEAD_BEEF);
        #3 chk("t1_cnt_end", {29'd0, ot_cnt}, 32'd0);
        cyc();

        // conflict with downstream stall: m1 wins and stays granted
        m0_req = 1; m0_addr = 32'h1C00_0100; m0_size = 2;
        m1_req = 1; m1_wr = 1; m1_addr = 32'h8000_0040; m1_size = 2; m1_wstrb = 4'hF;
        m1_wdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("t2_stall_addr", s_addr, 32'h8000_0040);
            chk("t2_stall_wr", {31'd0, s_wr}, 32'd1);
            chk("t2_stall_ok", {30'd0, m1_addr_ok, m0_addr_ok}, 32'd0);
            cyc();
        end
        s_addr_ok = 1;
        #3;
        chk("t2_wdata", s_wdata, 32'h1234_5678);
        chk("t2_acc_m1", {30'd0, m1_addr_ok, m0_addr_ok}, 32'd2);
        cyc();
        // second conflict right after an m1 accept: policy-dependent
        m1_wr = 0; m1_wstrb = 0; m1_wdata = 0; m1_addr = 32'h8000_0080;
        win = RR ? 1'b0 : 1'b1;
        #3;
        chk("t2_c2_addr", s_addr, win ? 32'h8000_0080 : 32'h1C00_0100);
        chk("t2_c2_ok", {30'd0, m1_addr_ok, m0_addr_ok}, win ? 32'd2 : 32'd1);
        cyc();
        if (win) m1_req = 0; else m0_req = 0;
        #3;
        chk("t2_c3_ok", {30'd0, m1_addr_ok, m0_addr_ok}, win ? 32'd1 : 32'd2);
        cyc();
        clr_m(); s_addr_ok = 0;
        #3 chk("t2_cnt3", {29'd0, ot_cnt}, 32'd3);
        cyc();
        respond(1'b1, 32'h11);
        respond(win, 32'h22);
        respond(~win, 32'h33);

        // fill to OT_DEPTH, then stall until a response frees a slot
        m0_req = 1; m0_size = 2; s_addr_ok = 1;
        for (int i = 0; i < OT; i++) begin
            m0_addr = 32'h100 + 32'(i * 4);
            #3 chk("t3_fill_ok", {31'd0, m0_addr_ok}, 32'd1);
            cyc();
        end
        m0_addr = 32'h200;
        #3;
        chk("t3_full_sreq", {31'd0, s_req}, 32'd0);
        chk("t3_full_ok", {31'd0, m0_addr_ok}, 32'd0);
        chk("t3_full_cnt", {29'd0, ot_cnt}, 32'd4);
        cyc();
        begin
            exp_t e;
            e.id = 0; e.rdata = 32'hA0;
            q.push_back(e);
        end
        s_data_ok = 1; s_rdata = 32'hA0;
        #3;
        chk("t3_pop_sreq", {31'd0, s_req}, 32'd0);
        chk("t3_pop_ok", {31'd0, m0_addr_ok}, 32'd0);
        cyc();
        s_data_ok = 0; s_rdata = 0;
        #3;
        chk("t3_after_cnt", {29'd0, ot_cnt}, 32'd3);
        chk("t3_after_sreq", {31'd0, s_req}, 32'd1);
        chk("t3_after_ok", {31'd0, m0_addr_ok}, 32'd1);
        cyc();
        clr_m(); s_addr_ok = 0;
        #3 chk("t3_refull", {29'd0, ot_cnt}, 32'd4);
        cyc();
        for (int i = 0; i < OT; i++) respond(1'b0, 32'hB0 + 32'(i));
        #3 chk("t3_drained", {29'd0, ot_cnt}, 32'd0);
        cyc();

        // ordered routing over two batches (pointer wrap)
        pat = 4'b0110;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) accept(pat[i], 32'h3000 + 32'(b * 16 + i));
            #3 chk("t4_cnt", {29'd0, ot_cnt}, 32'd4);
            for (int i = 0; i < 4; i++) respond(pat[i], 32'hC000 + 32'(b * 16 + i));
            pat = ~pat;
        end
        #3 chk("t4_cnt_end", {29'd0, ot_cnt}, 32'd0);
        cyc();

        // response with nothing outstanding
        s_data_ok = 1; s_rdata = 32'h5555;
        #3;
        chk("t5_no_dok", {30'd0, m1_data_ok, m0_data_ok}, 32'd0);
        chk("t5_no_rdata", m0_rdata | m1_rdata, 32'd0);
        chk("t5_err0", {31'd0, ot_err}, 32'd0);
        cyc();
        s_data_ok = 0; s_rdata = 0;
        #3 chk("t5_err1", {31'd0, ot_err}, 32'd1);
        cyc(); cyc();
        #3 chk("t5_err_sticky", {31'd0, ot_err}, 32'd1);
        chk("t5_cnt", {29'd0, ot_cnt}, 32'd0);
        cyc();

        // reset with two outstanding and a lock on m0
        accept(1'b0, 32'h4000);
        accept(1'b1, 32'h4004);
        m0_req = 1; m0_addr = 32'h4008;
        #3 chk("t6_cnt2", {29'd0, ot_cnt}, 32'd2);
        cyc();
        reset = 1; m1_req = 1; m1_addr = 32'h5000; s_data_ok = 1; s_rdata = 32'h77;
        #3;
        chk("t6_rst_sreq", {31'd0, s_req}, 32'd0);
        chk("t6_rst_saddr", s_addr, 32'd0);
        chk("t6_rst_dok", {30'd0, m1_data_ok, m0_data_ok}, 32'd0);
        chk("t6_rst_rdata", m0_rdata | m1_rdata, 32'd0);
        cyc();
        #3;
        chk("t6_cnt0", {29'd0, ot_cnt}, 32'd0);
        chk("t6_err0", {31'd0, ot_err}, 32'd0);
        cyc();
        reset = 0; s_data_ok = 0; s_rdata = 0; s_addr_ok = 1;
        #3;
        chk("t6_unlocked_addr", s_addr, 32'h5000);
        chk("t6_unlocked_ok", {30'd0, m1_addr_ok, m0_addr_ok}, 32'd2);
        cyc();
        clr_m(); s_addr_ok = 0;
        #3 chk("t6_cnt1", {29'd0, ot_cnt}, 32'd1);
        cyc();
        respond(1'b1, 32'h99);
        cyc();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
